// File: rtl/dp_ram_pkg.sv
// Shared types and constants for the dual-port RAM subsystem.
package dp_ram_pkg;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Requesting port identity
    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_t;

    // Number of address MSBs used as bank select
    localparam int BANK_BITS = 2;

endpackage

// File: rtl/dp_rr_arb2.sv
// Two-way request arbiter producing the winning port id.
// Build option DPA_FIXED_PRIO_EN: port A always wins ties and no
// last-grant history is kept. Default build: round robin on ties.
module dp_rr_arb2
    import dp_ram_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     req_a,
    input  logic     req_b,
    input  logic     update,
    output port_id_t winner
);

`ifdef DPA_FIXED_PRIO_EN

    // Clock, reset and update have no role without grant history
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, update, req_b};

    // A wins whenever it requests
    always_comb begin
        winner = req_a ? PORT_A : PORT_B;
    end

`else

    port_id_t last_grant;

    // Remember the most recent grant; B after reset so A wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PORT_B;
        end else if (update) begin
            last_grant <= winner;
        end
    end

    // Single requester wins outright, ties go to the port not granted last
    always_comb begin
        winner = PORT_A;
        if (req_a && req_b) begin
            winner = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (req_b) begin
            winner = PORT_B;
        end
    end

`endif

endmodule

// File: rtl/dp_bank_arbiter.sv
// Two-port arbiter and single-cycle access sequencer for the banked
// dual-port RAM. Registers the winning request split into bank select
// and in-bank offset, strobes the memory once, captures read data and
// pulses done back to the winner. Tie policy selectable through
// DPA_FIXED_PRIO_EN (see dp_rr_arb2).
module dp_bank_arbiter
    import dp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_a,
    input  logic                            req_b,
    input  logic                            we_a,
    input  logic                            we_b,
    input  logic [ADDR_WIDTH-1:0]           addr_a,
    input  logic [ADDR_WIDTH-1:0]           addr_b,
    input  logic [DATA_WIDTH-1:0]           wdata_a,
    input  logic [DATA_WIDTH-1:0]           wdata_b,
    output logic                            gnt_a,
    output logic                            gnt_b,
    output logic                            done_a,
    output logic                            done_b,
    output logic [DATA_WIDTH-1:0]           rdata_a,
    output logic [DATA_WIDTH-1:0]           rdata_b,
    output logic [BANK_BITS-1:0]            bank_sel,
    output logic [ADDR_WIDTH-BANK_BITS-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    output logic                            mem_en,
    output logic                            mem_we,
    input  logic [DATA_WIDTH-1:0]           mem_rdata
);

    localparam int OFF_W = ADDR_WIDTH - BANK_BITS;

    state_t                  state, state_next;
    port_id_t                winner;
    logic                    grant;
    logic                    cur_we, cur_we_next;
    logic                    gnt_a_next, gnt_b_next;
    logic                    done_a_next, done_b_next;
    logic                    mem_en_next, mem_we_next;
    logic [BANK_BITS-1:0]    bank_sel_next;
    logic [OFF_W-1:0]        mem_addr_next;
    logic [DATA_WIDTH-1:0]   mem_wdata_next;
    logic [DATA_WIDTH-1:0]   rdata_a_next, rdata_b_next;
    logic                    win_we;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [DATA_WIDTH-1:0]   win_wdata;

    // A grant is issued only when idle and someone is asking
    assign grant = (state == IDLE) && (req_a || req_b);

    dp_rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_a  (req_a),
        .req_b  (req_b),
        .update (grant),
        .winner (winner)
    );

    // Select the winning port's request fields
    always_comb begin
        win_we    = (winner == PORT_A) ? we_a    : we_b;
        win_addr  = (winner == PORT_A) ? addr_a  : addr_b;
        win_wdata = (winner == PORT_A) ? wdata_a : wdata_b;
    end

    // Next-state and next-output logic; strobes and done default low
    always_comb begin
        state_next     = state;
        cur_we_next    = cur_we;
        gnt_a_next     = gnt_a;
        gnt_b_next     = gnt_b;
        done_a_next    = 1'b0;
        done_b_next    = 1'b0;
        mem_en_next    = 1'b0;
        mem_we_next    = 1'b0;
        bank_sel_next  = bank_sel;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;
        rdata_a_next   = rdata_a;
        rdata_b_next   = rdata_b;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_next     = ACCESS;
                    gnt_a_next     = (winner == PORT_A);
                    gnt_b_next     = (winner == PORT_B);
                    mem_en_next    = 1'b1;
                    mem_we_next    = win_we;
                    cur_we_next    = win_we;
                    bank_sel_next  = win_addr[ADDR_WIDTH-1 -: BANK_BITS];
                    mem_addr_next  = win_addr[OFF_W-1:0];
                    mem_wdata_next = win_wdata;
                end
            end
            ACCESS: begin
                state_next = RESP;
            end
            RESP: begin
                // Memory read data is valid now, one cycle after the strobe
                state_next  = IDLE;
                gnt_a_next  = 1'b0;
                gnt_b_next  = 1'b0;
                done_a_next = gnt_a;
                done_b_next = gnt_b;
                if (!cur_we && gnt_a) rdata_a_next = mem_rdata;
                if (!cur_we && gnt_b) rdata_b_next = mem_rdata;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_we    <= 1'b0;
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            done_a    <= 1'b0;
            done_b    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            bank_sel  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_a   <= '0;
            rdata_b   <= '0;
        end else begin
            state     <= state_next;
            cur_we    <= cur_we_next;
            gnt_a     <= gnt_a_next;
            gnt_b     <= gnt_b_next;
            done_a    <= done_a_next;
            done_b    <= done_b_next;
            mem_en    <= mem_en_next;
            mem_we    <= mem_we_next;
            bank_sel  <= bank_sel_next;
            mem_addr  <= mem_addr_next;
            mem_wdata <= mem_wdata_next;
            rdata_a   <= rdata_a_next;
            rdata_b   <= rdata_b_next;
        end
    end

endmodule

// File: tb/tb_dp_bank_arbiter.sv
// Scoreboard bench for dp_bank_arbiter: a stimulus process pushes the
// expected accesses and completions, a monitor pops and compares them.
module tb_dp_bank_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_a = 1'b0, req_b = 1'b0;
    logic       we_a = 1'b0, we_b = 1'b0;
    logic [7:0] addr_a = '0, addr_b = '0;
    logic [7:0] wdata_a = '0, wdata_b = '0;
    logic       gnt_a, gnt_b, done_a, done_b;
    logic [7:0] rdata_a, rdata_b;
    logic [1:0] bank_sel;
    logic [5:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_rdata = '0;

    dp_bank_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .bank_sel(bank_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       port;   // 0 = A, 1 = B
        bit       we;
        bit [7:0] addr;
        bit [7:0] wdata;
        bit [7:0] rdata;
    } txn_t;

    txn_t     acc_q[$];
    txn_t     done_q[$];
    int       tests = 0;
    int       fails = 0;
    int       cyc = 0;
    int       en_cyc = 0;
    int       en_count = 0;
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] last_rd [2];
    bit       model_last;    // port granted last in the reference model

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read RAM seen by the DUT
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[{bank_sel, mem_addr}] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[{bank_sel, mem_addr}];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: decide arbitration order and data from the rules
    function automatic void expect_txn(input bit port, input bit we,
                                       input bit [7:0] addr, input bit [7:0] wdata);
        txn_t t;
        t.port = port; t.we = we; t.addr = addr; t.wdata = wdata;
        if (we) ref_mem[addr] = wdata;
        t.rdata = ref_mem[addr];
        acc_q.push_back(t);
        done_q.push_back(t);
        model_last = port;
    endfunction

    function automatic bit tie_winner();
`ifdef DPA_FIXED_PRIO_EN
        return 1'b0;
`else
        return model_last ? 1'b0 : 1'b1;
`endif
    endfunction

    // Monitor: compare strobe cycles and completions against the queues
    always @(negedge clk) begin
        if (rst_n) begin
            check("exclusive", {61'd0, gnt_a & gnt_b, done_a & done_b, mem_we & ~mem_en}, 64'd0);
            if (mem_en) begin
                en_count++;
                en_cyc = cyc;
                if (acc_q.size() == 0) begin
                    check("unexpected_mem_en", 64'd1, 64'd0);
                end else begin
                    txn_t t;
                    t = acc_q.pop_front();
                    check("bank_sel", {62'd0, bank_sel}, {62'd0, t.addr[7:6]});
                    check("mem_addr", {58'd0, mem_addr}, {58'd0, t.addr[5:0]});
                    check("mem_we", {63'd0, mem_we}, {63'd0, t.we});
                    check("gnt", {62'd0, gnt_b, gnt_a}, t.port ? 64'd2 : 64'd1);
                    if (t.we) check("mem_wdata", {56'd0, mem_wdata}, {56'd0, t.wdata});
                end
            end
            if (done_a || done_b) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    txn_t t;
                    logic [7:0] rd;
                    t = done_q.pop_front();
                    rd = t.port ? rdata_b : rdata_a;
                    check("done_port", {62'd0, done_b, done_a}, t.port ? 64'd2 : 64'd1);
                    check("done_latency", 64'(cyc - en_cyc), 64'd2);
                    if (!t.we) begin
                        check("rdata", {56'd0, rd}, {56'd0, t.rdata});
                        last_rd[t.port] = t.rdata;
                    end else begin
                        check("rdata_hold", {56'd0, rd}, {56'd0, last_rd[t.port]});
                    end
                end
            end
        end
    end

    function automatic logic [63:0] out_vec();
        return {26'd0, gnt_a, gnt_b, done_a, done_b, mem_en, mem_we,
                bank_sel, mem_addr, mem_wdata, rdata_a, rdata_b};
    endfunction

    // One round: raise the selected requests, drop each on its done pulse
    task automatic do_round(input bit ra, input bit rb, input bit wa, input bit wb,
                            input bit [7:0] aa, input bit [7:0] ab,
                            input bit [7:0] da, input bit [7:0] db);
        int n;
        if (ra && rb) begin
            bit w;
            w = tie_winner();
            if (w == 1'b0) begin
                expect_txn(1'b0, wa, aa, da);
                expect_txn(1'b1, wb, ab, db);
            end else begin
                expect_txn(1'b1, wb, ab, db);
                expect_txn(1'b0, wa, aa, da);
            end
        end else if (ra) begin
            expect_txn(1'b0, wa, aa, da);
        end else if (rb) begin
            expect_txn(1'b1, wb, ab, db);
        end
        req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
        req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
        n = 0;
        while ((req_a || req_b) && n < 20) begin
            @(posedge clk); #1;
            if (done_a) req_a = 1'b0;
            if (done_b) req_b = 1'b0;
            n++;
        end
        if (req_a || req_b) begin
            check("round_timeout", 64'd1, 64'd0);
            req_a = 1'b0; req_b = 1'b0;
        end
    endtask

    task automatic reset_model();
        acc_q.delete();
        done_q.delete();
        model_last = 1'b1;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
    endtask

    initial begin
        int n;
        int base;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'((i * 7 + 3) & 255);
        end
        reset_model();

        // Reset held with a request pending: everything stays at reset value
        req_a = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("reset_outputs", out_vec(), 64'd0);
        end
        @(posedge clk); #1;
        req_a = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed write then read back by A
        do_round(1, 0, 1, 0, 8'hC5, 8'h00, 8'h3A, 8'h00);
        do_round(1, 0, 0, 0, 8'hC5, 8'h00, 8'h00, 8'h00);

        // Tie held: alternating grants (A first again only with fixed priority)
        repeat (2) do_round(1, 1, 0, 1, 8'h12, 8'h93, 8'h00, 8'h77);

        // Bank coverage from B
        for (int b = 0; b < 4; b++)
            do_round(0, 1, 0, 0, 8'h00, 8'(b << 6), 8'h00, 8'h00);

        // Randomized mix of single and tied requests
        for (int k = 0; k < 60; k++) begin
            bit ra, rb;
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            if (!ra && !rb) ra = 1'b1;
            do_round(ra, rb, 1'($urandom), 1'($urandom),
                     {2'($urandom), 4'd0, 2'($urandom)},
                     {2'($urandom), 4'd0, 2'($urandom)},
                     8'($urandom), 8'($urandom));
        end

        // Request dropped during ACCESS still completes exactly once
        base = en_count;
        expect_txn(1'b0, 1'b0, 8'h41, 8'h00);
        req_a = 1'b1; we_a = 1'b0; addr_a = 8'h41;
        n = 0;
        while (!gnt_a && n < 10) begin @(posedge clk); #1; n++; end
        req_a = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("drop_one_access", 64'(en_count - base), 64'd1);
        check("drop_done_seen", 64'(done_q.size()), 64'd0);

        // Reset during RESP aborts B's read asynchronously
        expect_txn(1'b1, 1'b0, 8'h82, 8'h00);
        req_b = 1'b1; we_b = 1'b0; addr_b = 8'h82;
        n = 0;
        while (!gnt_b && n < 10) begin @(posedge clk); #1; n++; end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", out_vec(), 64'd0);
        req_b = 1'b0;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // First tie after reset goes to A
        do_round(1, 1, 0, 0, 8'h05, 8'hC6, 8'h00, 8'h00);

        repeat (4) @(posedge clk);
        #1;
        check("queues_drained", 64'(acc_q.size() + done_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute guard against a stuck run
    initial begin
        #200000;
        $display("FAIL global_timeout: cycle %0d reached without finishing", cyc);
        $fatal(1);
    end

endmodule
